// File: rtl/hazard_ctrl_gen.sv
// hazard_ctrl_gen: stage enables, flushes and forwarding selects for the 5-stage core,
// with a load-use bubble machine, memory freeze and saturating stall/flush counters.
module hazard_ctrl_gen #(
  parameter int RA_W = 4,
  parameter int NSRC = 3,
  parameter int LOAD_LAT = 1,
  parameter int EXCL_PC = 1,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NSRC*RA_W-1:0] RAD,
  input  logic [NSRC*RA_W-1:0] RAE,
  input  logic [RA_W-1:0]      WA3E,
  input  logic [RA_W-1:0]      WA3M,
  input  logic [RA_W-1:0]      WA3W,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 MemtoRegM,
  input  logic                 PCSrcD,
  input  logic                 PCSrcE,
  input  logic                 PCSrcM,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  input  logic                 MemReadyM,
  input  logic                 ClrCnt,
  output logic [NSRC*2-1:0]    Forward,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [CNT_W-1:0]     StallCnt,
  output logic [CNT_W-1:0]     FlushCnt
);
  typedef enum logic {IDLE, LDWAIT} state_t;
  state_t state, stateNext;
  logic [1:0] cnt, cntNext;
  logic ldHit, ldStall, pcPend, frz;

  function automatic logic isMatch(input logic [RA_W-1:0] a, input logic [RA_W-1:0] w, input logic we);
    return we && (a == w) && !(EXCL_PC != 0 && a == {RA_W{1'b1}});
  endfunction

  always_comb begin
    Forward = '0;
    ldHit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      Forward[2*i +: 2] = !RST ? 2'b00 :
        (isMatch(RAE[i*RA_W +: RA_W], WA3M, RegWriteM) && !(LOAD_LAT == 2 && MemtoRegM)) ? 2'b10 :
        isMatch(RAE[i*RA_W +: RA_W], WA3W, RegWriteW) ? 2'b01 : 2'b00;
      ldHit |= isMatch(RAD[i*RA_W +: RA_W], WA3E, RegWriteE && MemtoRegE);
    end
  end

  // A taken branch during LDWAIT squashes the held instruction, so the bubble is dropped.
  always_comb begin
    frz = !MemReadyM;
    pcPend = PCSrcD | PCSrcE | PCSrcM;
    ldStall = (state == IDLE) ? ldHit : !BranchTakenE;
    stateNext = state;
    cntNext = cnt;
    if (!frz && state == IDLE && ldHit && LOAD_LAT > 1) begin
      stateNext = LDWAIT;
      cntNext = 2'(LOAD_LAT - 1);
    end else if (!frz && state == LDWAIT) begin
      stateNext = (BranchTakenE || cnt == 2'd1) ? IDLE : LDWAIT;
      cntNext = BranchTakenE ? 2'd0 : cnt - 2'd1;
    end
    StallF = RST && (frz || ldStall || pcPend);
    StallD = RST && (frz || ldStall);
    StallE = RST && frz;
    StallM = RST && frz;
    FlushD = !RST || (!frz && (pcPend || PCSrcW || BranchTakenE));
    FlushE = !RST || (!frz && (ldStall || BranchTakenE));
    FlushW = !RST || frz;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (ClrCnt) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && StallCnt != {CNT_W{1'b1}}) StallCnt <= StallCnt + CNT_W'(1);
      if ((FlushD || FlushE) && FlushCnt != {CNT_W{1'b1}}) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
endmodule
